// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command controller.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    WR_BUS,
    RD_BUS,
    NEXT,
    DONE
  } state_t;

  localparam int unsigned CMD_RW_BIT       = 7;
  localparam logic [7:0]  ERR_BYTE_DEFAULT = 8'hEE;

endpackage

// File: rtl/spi_bus_timeout.sv
// Bus access watchdog: counts cycles of an outstanding request and flags
// expiry in the TIMEOUT_CYCLES-th cycle the request has been held.
module spi_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned     CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles, holding at the last value until cleared
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: turns received SPI bytes into register-bus
// reads/writes and feeds read data back to the slave for MISO.
// Optional burst mode (address auto-increment) under SPI_CMD_AUTOINC_EN.
module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned      ADDR_W         = 7,
  parameter int unsigned      DATA_W         = 8,
  parameter int unsigned      TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_BYTE      = DATA_W'(ERR_BYTE_DEFAULT)
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_cs_n,
  input  logic              in_rx_valid,
  input  logic [DATA_W-1:0] in_rx_byte,
  output logic [DATA_W-1:0] o_tx_byte,
  output logic              o_tx_load,
  output logic              o_reg_req,
  output logic              o_reg_we,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_reg_wdata,
  input  logic              in_reg_ack,
  input  logic [DATA_W-1:0] in_reg_rdata,
  output logic              o_busy,
  output logic              o_err_timeout,
  output logic              o_overrun
);

  state_t state, state_nxt;
  logic   cs_prev;
  logic   cs_fall, cs_rise;
  logic   in_bus;
  logic   expire;

`ifdef SPI_CMD_AUTOINC_EN
  logic   rd_burst;
`endif

  assign cs_fall = cs_prev && !in_cs_n;
  assign cs_rise = !cs_prev && in_cs_n;
  assign in_bus  = (state == WR_BUS) || (state == RD_BUS);

  spi_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (in_clk),
    .rst   (in_rst),
    .clr   (!in_bus),
    .en    (in_bus),
    .expire(expire)
  );

  // State register
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; deselect overrides everything, ack beats expiry
  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (cs_fall) state_nxt = CMD;
        CMD:     if (in_rx_valid) state_nxt = in_rx_byte[CMD_RW_BIT] ? RD_BUS : WDATA;
        WDATA:   if (in_rx_valid) state_nxt = WR_BUS;
        WR_BUS,
        RD_BUS: begin
          if (in_reg_ack)  state_nxt = NEXT;
          else if (expire) state_nxt = DONE;
        end
`ifdef SPI_CMD_AUTOINC_EN
        // Read bursts advance on the dummy byte so the next read overlaps its shift-out
        NEXT: begin
          if (!rd_burst)        state_nxt = WDATA;
          else if (in_rx_valid) state_nxt = RD_BUS;
        end
`else
        NEXT:    state_nxt = DONE;
`endif
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    o_busy    = (state != IDLE);
    o_reg_req = in_bus;
    o_reg_we  = (state == WR_BUS);
  end

  // Datapath: cs edge, address/data latches, tx byte and status pulses
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cs_prev       <= 1'b1;
      o_reg_addr    <= '0;
      o_reg_wdata   <= '0;
      o_tx_byte     <= '0;
      o_tx_load     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;
`ifdef SPI_CMD_AUTOINC_EN
      rd_burst      <= 1'b0;
`endif
    end else begin
      cs_prev       <= in_cs_n;
      o_tx_load     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;
      if (!cs_rise) begin
        unique case (state)
          CMD: begin
            if (in_rx_valid) begin
              o_reg_addr <= in_rx_byte[ADDR_W-1:0];
`ifdef SPI_CMD_AUTOINC_EN
              rd_burst   <= in_rx_byte[CMD_RW_BIT];
`endif
            end
          end
          WDATA: begin
            if (in_rx_valid) o_reg_wdata <= in_rx_byte;
          end
          WR_BUS: begin
            if (in_rx_valid) o_overrun <= 1'b1;
            if (!in_reg_ack && expire) o_err_timeout <= 1'b1;
          end
          RD_BUS: begin
            if (in_rx_valid) o_overrun <= 1'b1;
            if (in_reg_ack) begin
              o_tx_byte <= in_reg_rdata;
              o_tx_load <= 1'b1;
            end else if (expire) begin
              o_tx_byte     <= ERR_BYTE;
              o_tx_load     <= 1'b1;
              o_err_timeout <= 1'b1;
            end
          end
`ifdef SPI_CMD_AUTOINC_EN
          NEXT: begin
            if (!rd_burst || in_rx_valid) o_reg_addr <= o_reg_addr + ADDR_W'(1);
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
